// File: rtl/lfu_pkg.sv
// Shared definitions for the LFU replacement controller.
//   CNT_RST_VAL : counter value after reset and after a fresh fill.
//   clog2       : ceiling log2, used to size entry indices.
//   params_ok   : legal-range check for NUM_ENTRIES and CNT_W.
package lfu_pkg;

  localparam int CNT_RST_VAL = 1;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

  // NUM_ENTRIES must be a power of two in 2..16; CNT_W must be in 2..8.
  function automatic bit params_ok(input int num_entries, input int cnt_w);
    bit pow2;
    pow2 = (num_entries > 0) && ((num_entries & (num_entries - 1)) == 0);
    return pow2 && (num_entries >= 2) && (num_entries <= 16) &&
           (cnt_w >= 2) && (cnt_w <= 8);
  endfunction

endpackage

// File: rtl/lfu_argmin_tree.sv
// Combinational tournament tree returning the index of the smallest counter.
// Ports:
//   i_cnt_flat : all counters, entry k at bits [k*CNT_W +: CNT_W]
//   o_min_idx  : index of the minimum; the lower index wins every tie
module lfu_argmin_tree
  import lfu_pkg::*;
#(
  parameter int NUM_ENTRIES = 4,
  parameter int CNT_W       = 4,
  localparam int IDX_W      = clog2(NUM_ENTRIES)
) (
  input  logic [NUM_ENTRIES*CNT_W-1:0] i_cnt_flat,
  output logic [IDX_W-1:0]             o_min_idx
);

  // Level 0 holds the leaves; level l holds NUM_ENTRIES>>l survivors.
  logic [CNT_W-1:0] w_val [IDX_W+1][NUM_ENTRIES];
  logic [IDX_W-1:0] w_idx [IDX_W+1][NUM_ENTRIES];

  always_comb begin
    for (int l = 0; l <= IDX_W; l++) begin
      for (int k = 0; k < NUM_ENTRIES; k++) begin
        w_val[l][k] = '0;
        w_idx[l][k] = '0;
      end
    end
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      w_val[0][k] = i_cnt_flat[k*CNT_W +: CNT_W];
      w_idx[0][k] = IDX_W'(k);
    end
    for (int l = 0; l < IDX_W; l++) begin
      for (int k = 0; k < (NUM_ENTRIES >> (l + 1)); k++) begin
        // Left child carries the lower indices, so it wins on equality.
        if (w_val[l][2*k] <= w_val[l][2*k+1]) begin
          w_val[l+1][k] = w_val[l][2*k];
          w_idx[l+1][k] = w_idx[l][2*k];
        end else begin
          w_val[l+1][k] = w_val[l][2*k+1];
          w_idx[l+1][k] = w_idx[l][2*k+1];
        end
      end
    end
  end

  assign o_min_idx = w_idx[IDX_W][0];

endmodule

// File: rtl/lfu_repl_ctrl.sv
// Least-frequently-used replacement controller for an N-entry buffer pool.
// One saturating use-counter per entry; referencing a saturated entry halves
// every counter (aging). A replacement request returns the least-used entry
// one cycle later and restarts its counter as a fresh fill.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_ref_vld      : entry i_ref_idx was referenced this cycle
//   i_ref_idx      : referenced entry
//   i_repl_req     : single-cycle replacement request
//   o_repl_vld     : one-cycle pulse, o_repl_idx holds the new victim
//   o_repl_idx     : victim index, held between requests
//   o_age_evt      : one-cycle pulse after an aging pass
// Handshake: all strobes are fire-and-forget; there is no backpressure. Each
// cycle with i_repl_req=1 yields exactly one o_repl_vld pulse in the next cycle.
module lfu_repl_ctrl
  import lfu_pkg::*;
#(
  parameter int NUM_ENTRIES = 4,
  parameter int CNT_W       = 4,
  localparam int IDX_W      = clog2(NUM_ENTRIES)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ref_vld,
  input  logic [IDX_W-1:0] i_ref_idx,
  input  logic             i_repl_req,
  output logic             o_repl_vld,
  output logic [IDX_W-1:0] o_repl_idx,
  output logic             o_age_evt
);

  if (!params_ok(NUM_ENTRIES, CNT_W)) begin : g_param_check
    $error("lfu_repl_ctrl: illegal NUM_ENTRIES=%0d or CNT_W=%0d", NUM_ENTRIES, CNT_W);
  end

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CNT_RST_VAL);
  // (CNT_MAX >> 1) + 1 equals 2**(CNT_W-1).
  localparam logic [CNT_W-1:0] AGE_SEED = CNT_W'(2 ** (CNT_W - 1));

  logic [CNT_W-1:0]             r_cnt [NUM_ENTRIES];
  logic                         r_repl_vld;
  logic [IDX_W-1:0]             r_repl_idx;
  logic                         r_age_evt;

  logic [NUM_ENTRIES*CNT_W-1:0] w_cnt_flat;
  logic [IDX_W-1:0]             w_victim;
  logic [CNT_W-1:0]             w_nxt [NUM_ENTRIES];
  logic                         w_age;
  logic                         w_collide;

  always_comb begin
    w_cnt_flat = '0;
    for (int k = 0; k < NUM_ENTRIES; k++) w_cnt_flat[k*CNT_W +: CNT_W] = r_cnt[k];
  end

  // Victim is chosen from the registered (pre-update) counters.
  lfu_argmin_tree #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .CNT_W       (CNT_W)
  ) u_argmin (
    .i_cnt_flat (w_cnt_flat),
    .o_min_idx  (w_victim)
  );

  always_comb begin
    for (int k = 0; k < NUM_ENTRIES; k++) w_nxt[k] = r_cnt[k];
    w_age     = 1'b0;
    // A reference to the entry being replaced is absorbed by the fill.
    w_collide = i_repl_req && i_ref_vld && (i_ref_idx == w_victim);
    if (i_ref_vld && !w_collide) begin
      if (r_cnt[i_ref_idx] == CNT_MAX) begin
        w_age = 1'b1;
        for (int k = 0; k < NUM_ENTRIES; k++) w_nxt[k] = r_cnt[k] >> 1;
        w_nxt[i_ref_idx] = AGE_SEED;
      end else begin
        w_nxt[i_ref_idx] = r_cnt[i_ref_idx] + 1'b1;
      end
    end
    // Fill is applied last so it overrides any halving of the victim.
    if (i_repl_req) w_nxt[w_victim] = CNT_INIT;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_ENTRIES; k++) r_cnt[k] <= CNT_INIT;
      r_repl_vld <= 1'b0;
      r_repl_idx <= '0;
      r_age_evt  <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_ENTRIES; k++) r_cnt[k] <= w_nxt[k];
      r_repl_vld <= i_repl_req;
      if (i_repl_req) r_repl_idx <= w_victim;
      r_age_evt  <= w_age;
    end
  end

  assign o_repl_vld = r_repl_vld;
  assign o_repl_idx = r_repl_idx;
  assign o_age_evt  = r_age_evt;

endmodule
